// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous FIFO: wrap-bit read pointer,
// level flags, 1-cycle-latency RAM fetch and a 2-entry first-word-fall-through
// prefetch buffer presenting data on a valid/ready interface.
module fifo_read_ctrl #(
    parameter int unsigned BUFFER_WIDTH       = 3,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH:0]   write_Pointer,
    input  logic                    flush,
    output logic [BUFFER_WIDTH:0]   read_Pointer,
    output logic [BUFFER_WIDTH-1:0] read_Address,
    output logic                    mem_Read_Enable,
    input  logic [DATA_WIDTH-1:0]   mem_Read_Data,
    output logic [DATA_WIDTH-1:0]   data_Out,
    output logic                    data_Valid,
    input  logic                    data_Ready,
    output logic [BUFFER_WIDTH+1:0] fill_Level,
    output logic                    sig_Empty,
    output logic                    sig_Almost_Empty,
    output logic                    sig_Pointer_Error
);

    localparam int unsigned PTR_W  = BUFFER_WIDTH + 1;
    localparam int unsigned FILL_W = BUFFER_WIDTH + 2;
    localparam int unsigned DEPTH  = 1 << BUFFER_WIDTH;

    // Encoding equals the number of words held in the prefetch buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t             state_q, state_d;
    logic [PTR_W-1:0]       read_ptr_q, read_ptr_d;
    logic                   fetch_pending_q, fetch_pending_d;
    logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;

    logic [PTR_W-1:0]       storage;
    logic [1:0]             buf_count;
    logic [2:0]             occupancy;
    logic                   pop;
    logic                   capture;
    logic                   fetch;

    // Next-state logic: fetch decision, pointer advance, buffer shift/capture.
    always_comb begin
        state_d         = state_q;
        read_ptr_d      = read_ptr_q;
        fetch_pending_d = fetch_pending_q;
        buf0_d          = buf0_q;
        buf1_d          = buf1_q;
        error_d         = error_q;

        storage   = write_Pointer - read_ptr_q;
        buf_count = 2'(state_q);
        occupancy = 3'(buf_count) + 3'(fetch_pending_q);
        pop       = valid_q & data_Ready;
        capture   = fetch_pending_q;
        // Never let buffered + in-flight words exceed two after this edge.
        fetch     = (storage != '0) && (occupancy < (3'd2 + 3'(pop))) && !flush;

        if (flush) begin
            // Drop everything unread, including a word still coming from RAM.
            read_ptr_d      = write_Pointer;
            state_d         = BUF_EMPTY;
            fetch_pending_d = 1'b0;
            error_d         = 1'b0;
        end else begin
            error_d         = error_q | (storage > PTR_W'(DEPTH));
            fetch_pending_d = fetch;
            if (fetch) begin
                read_ptr_d = read_ptr_q + PTR_W'(1);
            end
            case (state_q)
                BUF_EMPTY: begin
                    if (capture) begin
                        buf0_d  = mem_Read_Data;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({pop, capture})
                        2'b10:   state_d = BUF_EMPTY;
                        2'b01: begin
                            buf1_d  = mem_Read_Data;
                            state_d = BUF_TWO;
                        end
                        2'b11:   buf0_d = mem_Read_Data;
                        default: state_d = BUF_ONE;
                    endcase
                end
                BUF_TWO: begin
                    if (pop) begin
                        buf0_d = buf1_q;
                        if (capture) begin
                            buf1_d = mem_Read_Data;
                        end else begin
                            state_d = BUF_ONE;
                        end
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end

        valid_d = (state_d != BUF_EMPTY);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= BUF_EMPTY;
            read_ptr_q      <= '0;
            fetch_pending_q <= 1'b0;
            buf0_q          <= '0;
            buf1_q          <= '0;
            valid_q         <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            read_ptr_q      <= read_ptr_d;
            fetch_pending_q <= fetch_pending_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            valid_q         <= valid_d;
            error_q         <= error_d;
        end
    end

    // Output mapping; level flags count storage, in-flight and buffered words.
    assign read_Pointer      = read_ptr_q;
    assign read_Address      = read_ptr_q[BUFFER_WIDTH-1:0];
    assign mem_Read_Enable   = fetch;
    assign data_Out          = buf0_q;
    assign data_Valid        = valid_q;
    assign fill_Level        = FILL_W'(storage) + FILL_W'(fetch_pending_q) + FILL_W'(buf_count);
    assign sig_Empty         = (fill_Level == '0);
    assign sig_Almost_Empty  = (fill_Level <= FILL_W'(ALMOST_EMPTY_LEVEL));
    assign sig_Pointer_Error = error_q;

endmodule
